smss32_pow_seq: RTL and testbench

//  Iterative GF(2^6) power-map engine: y = x^E via left-to-right square-and-multiply
//  on ONE shared GF(2^6) multiplier, sequenced by a small FSM. Runtime-exponent,

---
 rtl/smss32_pow_seq_if.sv | 26 ++
 rtl/smss32_pow_seq.sv | 137 +++++++++++++
 tb/tb_smss32_pow_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smss32_pow_seq_if.sv
// Purpose : stream handshake bundle for the GF(2^6) power-map engine.
// Signals : in_valid/in_ready/in_x/in_e  - job request (base x, exponent E)
//           out_valid/out_ready/out_y    - result x^E
//           busy                         - engine is working or holding a result
// Modports: master drives the request side and consumes the result,
//           slave is the engine itself.
interface smss32_pow_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_x;
  logic [5:0] in_e;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;
  logic       busy;

  modport master (
    output in_valid, in_x, in_e, out_ready,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_e, out_ready,
    output in_ready, out_valid, out_y, busy
  );
endinterface

// File: rtl/smss32_pow_seq.sv
// Purpose : iterative y = x^E over GF(2^6) (poly x^6+x+1, polynomial basis)
//           using left-to-right square-and-multiply on one shared multiplier.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - smss32_pow_seq_if.slave (request/result handshakes, busy)
// Params  : N (field degree, 6 only), POLY (reduction polynomial),
//           CONST_TIME (1: a multiply step is spent on every exponent bit).
//
// state | meaning
// IDLE  | waiting for a job, in_ready=1
// SQ    | acc <= acc^2 for exponent bit idx
// MUL   | acc <= acc*base if e[idx]=1 (otherwise a discarded dummy product)
// DONE  | out_y/out_valid held until out_ready
module smss32_pow_seq #(
  parameter int          N          = 6,
  parameter logic [6:0]  POLY       = 7'b1000011,
  parameter bit          CONST_TIME = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  smss32_pow_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQ   = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] IDX_TOP = 3'd5;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] base_q, base_d;
  logic [N-1:0] e_q, e_d;
  logic [2:0]   idx_q, idx_d;
  logic [N-1:0] out_y_q, out_y_d;
  logic         out_valid_q, out_valid_d;

  logic [N-1:0]   mul_a, mul_b, mul_p;
  logic [2*N-2:0] prod;
  logic           e_bit;

  // Shared multiplier: operand B is the only thing that changes between
  // squaring (acc,acc) and multiplying (acc,base).
  always_comb begin
    mul_a = acc_q;
    mul_b = (state_q == S_MUL) ? base_q : acc_q;
    prod  = '0;
    for (int i = 0; i < N; i++) begin
      if (mul_b[i]) prod = prod ^ ({{(N-1){1'b0}}, mul_a} << i);
    end
    // Fold the high terms down from the top so each fold can only
    // create lower-order terms that a later iteration clears.
    for (int i = 2*N-2; i >= N; i--) begin
      if (prod[i]) prod = prod ^ ({{(N-2){1'b0}}, POLY} << (i-N));
    end
    mul_p = prod[N-1:0];
  end

  assign e_bit = e_q[idx_q];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    e_d         = e_q;
    idx_d       = idx_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          base_d  = bus.in_x;
          e_d     = bus.in_e;
          acc_d   = {{(N-1){1'b0}}, 1'b1};
          idx_d   = IDX_TOP;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        acc_d = mul_p;
        if (e_bit || CONST_TIME) begin
          state_d = S_MUL;
        end else if (idx_q == 3'd0) begin
          out_y_d     = mul_p;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      S_MUL: begin
        if (e_bit) acc_d = mul_p;
        if (idx_q == 3'd0) begin
          out_y_d     = acc_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = S_SQ;
        end
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= {{(N-1){1'b0}}, 1'b1};
      base_q      <= '0;
      e_q         <= '0;
      idx_q       <= IDX_TOP;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      e_q         <= e_d;
      idx_q       <= idx_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_smss32_pow_seq.sv
// Bench for smss32_pow_seq: one instance with CONST_TIME=0 and one with
// CONST_TIME=1. Drivers push {expected y, expected latency, accept cycle}
// into a per-instance queue; a negedge monitor pops on each new result.
module tb_smss32_pow_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] y;
    int         lat;
    int         acc;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  item_t cur[2];
  bit    in_job[2];

  logic       tv_v[2];
  logic [5:0] tv_x[2];
  logic [5:0] tv_e[2];
  logic       rdy_force[2];
  logic       rdy_rand[2];
  logic       rdy_rnd[2];
  logic       rdy_eff[2];
  logic       ov[2], ir[2], bz[2];
  logic [5:0] oy[2];

  smss32_pow_seq_if if0();
  smss32_pow_seq_if if1();

  smss32_pow_seq #(.CONST_TIME(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  smss32_pow_seq #(.CONST_TIME(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign rdy_eff[0] = rdy_rand[0] ? rdy_rnd[0] : rdy_force[0];
  assign rdy_eff[1] = rdy_rand[1] ? rdy_rnd[1] : rdy_force[1];

  assign if0.in_valid  = tv_v[0];
  assign if0.in_x      = tv_x[0];
  assign if0.in_e      = tv_e[0];
  assign if0.out_ready = rdy_eff[0];
  assign if1.in_valid  = tv_v[1];
  assign if1.in_x      = tv_x[1];
  assign if1.in_e      = tv_e[1];
  assign if1.out_ready = rdy_eff[1];

  assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;
  assign ir[0] = if0.in_ready;   assign ir[1] = if1.in_ready;
  assign bz[0] = if0.busy;       assign bz[1] = if1.busy;
  assign oy[0] = if0.out_y;      assign oy[1] = if1.out_y;

  always @(negedge clk) begin
    rdy_rnd[0] <= ($urandom_range(0, 3) != 0);
    rdy_rnd[1] <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, d, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: plain shift-and-reduce multiply, exponent by repetition.
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, aa;
    logic       c;
    r  = 6'h00;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      c  = aa[5];
      aa = {aa[4:0], 1'b0};
      if (c) aa = aa ^ 6'h03;
    end
    return r;
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] x, input int e);
    logic [5:0] y;
    y = 6'h01;
    for (int i = 0; i < e; i++) y = gmul(y, x);
    return y;
  endfunction

  task automatic push_exp(input int d, input item_t it);
    if (d == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  task automatic mon_step(input int d);
    item_t it;
    bit    got;
    if (rst) begin
      in_job[d] = 1'b0;
      return;
    end
    if (ov[d]) begin
      if (!in_job[d]) begin
        got = 1'b0;
        if (d == 0 && q0.size() > 0) begin it = q0.pop_front(); got = 1'b1; end
        if (d == 1 && q1.size() > 0) begin it = q1.pop_front(); got = 1'b1; end
        if (!got) begin
          chk("unexpected_output", d, 1, 0);
          it.y = oy[d]; it.lat = 0; it.acc = 0;
        end else begin
          chk("out_y", d, int'(oy[d]), int'(it.y));
          chk("latency", d, cyc - it.acc, it.lat);
        end
        cur[d]    = it;
        in_job[d] = 1'b1;
      end else begin
        chk("out_y_stable", d, int'(oy[d]), int'(cur[d].y));
      end
    end else begin
      in_job[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic do_job(input int d, input logic [5:0] x, input logic [5:0] e,
                        input logic [5:0] y, input int lat, input int gap);
    item_t it;
    int    t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    tv_x[d] = x;
    tv_e[d] = e;
    tv_v[d] = 1'b1;
    t = 0;
    while (!ir[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ir[d]) begin
      chk("accept_timeout", d, 0, 1);
      tv_v[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    it.y = y; it.lat = lat; it.acc = cyc;
    push_exp(d, it);
    tv_v[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    int sz;
    t  = 0;
    sz = (d == 0) ? q0.size() : q1.size();
    while ((sz != 0 || in_job[d] || ov[d]) && t < 500) begin
      @(negedge clk);
      t++;
      sz = (d == 0) ? q0.size() : q1.size();
    end
    chk("drain_pending", d, sz, 0);
    chk("drain_busy", d, int'(bz[d]), 0);
  endtask

  task automatic run_all(input int d);
    logic [5:0] x, e;
    int         lat;
    for (int xi = 0; xi < 64; xi++) begin
      for (int ei = 0; ei < 64; ei++) begin
        x   = 6'(xi);
        e   = 6'(ei);
        lat = (d == 0) ? 6 + $countones(e) : 12;
        do_job(d, x, e, gpow(x, ei), lat, $urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      tv_v[d] = 1'b0; tv_x[d] = 6'h00; tv_e[d] = 6'h00;
      rdy_force[d] = 1'b1; rdy_rand[d] = 1'b0;
      in_job[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, int'(ov[d]), 0);
      chk("rst_in_ready", d, int'(ir[d]), 1);
      chk("rst_busy", d, int'(bz[d]), 0);
      chk("rst_out_y", d, int'(oy[d]), 0);
    end
    rst = 1'b0;

    // Reset during SQ: job is dropped, nothing comes out afterwards.
    @(negedge clk);
    tv_x[0] = 6'h02; tv_e[0] = 6'h3F; tv_v[0] = 1'b1;
    @(posedge clk); #1;
    tv_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 0, int'(bz[0]), 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 0, int'(ov[0]), 0);
    chk("midrst_in_ready", 0, int'(ir[0]), 1);
    chk("midrst_busy", 0, int'(bz[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_out_valid", 0, int'(ov[0]), 0);

    // Directed, hand-computed vectors.
    do_job(0, 6'h20, 6'd2,  6'h30, 7,  1);
    do_job(0, 6'h02, 6'd62, 6'h21, 11, 1);
    do_job(0, 6'h02, 6'd63, 6'h01, 12, 0);
    do_job(0, 6'h00, 6'd0,  6'h01, 6,  0);
    do_job(0, 6'h2B, 6'd0,  6'h01, 6,  2);
    do_job(0, 6'h00, 6'd5,  6'h00, 8,  0);
    do_job(1, 6'h02, 6'd62, 6'h21, 12, 0);
    do_job(1, 6'h00, 6'd0,  6'h01, 12, 0);
    do_job(1, 6'h20, 6'd2,  6'h30, 12, 0);
    drain(0);
    drain(1);

    // Backpressure: x=2, E=3 -> x^3 = 6'h08, latency 6+2.
    rdy_force[0] = 1'b0;
    do_job(0, 6'h02, 6'd3, 6'h08, 8, 0);
    t = 0;
    while (!ov[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", 0, int'(ov[0]), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 0, int'(ir[0]), 0);
      chk("bp_out_valid_hold", 0, int'(ov[0]), 1);
      tv_x[0] = 6'h3F; tv_e[0] = 6'h3F;
      tv_v[0] = (i % 2 == 0);
    end
    @(negedge clk);
    tv_v[0] = 1'b0;
    rdy_force[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 0, int'(ov[0]), 0);
    chk("bp_release_in_ready", 0, int'(ir[0]), 1);
    chk("bp_release_busy", 0, int'(bz[0]), 0);
    drain(0);

    // Exhaustive sweep on both instances with random gaps and stalls.
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    fork
      run_all(0);
      run_all(1);
    join
    rdy_rand[0] = 1'b0;
    rdy_rand[1] = 1'b0;
    drain(0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
